// File: rtl/lsu_mem_master_pkg.sv
// Constants and types for the load/store unit. The MEM-stage control
// decoder uses the same constants.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CTRL_ZEXT = 2;

  typedef enum logic {
    IDLE,
    SPLIT
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Links the MEM stage and the data memory to the LSU. The master modport is
// the LSU's view. The slave modport is the view of the core and the memory.
interface lsu_mem_master_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [2:0]            req_ctrl;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  busy;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] mem_A;
  logic                  mem_WE;
  logic [2:0]            mem_AddressingControl;
  logic [DATA_WIDTH-1:0] mem_WD;
  logic [DATA_WIDTH-1:0] mem_RD;

  modport master (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_RD,
    output busy, resp_valid, resp_rdata, resp_err,
    output mem_A, mem_WE, mem_AddressingControl, mem_WD
  );

  modport slave (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_RD,
    input  busy, resp_valid, resp_rdata, resp_err,
    input  mem_A, mem_WE, mem_AddressingControl, mem_WD
  );
endinterface

// File: rtl/lsu_mem_master_load_extend.sv
// Sign or zero extension of loaded data, selected by size and the zext bit.
// The invalid size gives 0.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size_i,
  input  logic                  zext_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_BYTE: data_o = {{(DATA_WIDTH-8){~zext_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{(DATA_WIDTH-16){~zext_i & data_i[15]}}, data_i[15:0]};
      SZ_WORD: data_o = data_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Data-memory initiator. Aligned accesses go straight through in one cycle.
// Misaligned half/word accesses are split into byte accesses, or flagged as errors.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input logic             clk,
  input logic             rst,
  lsu_mem_master_if.master bus
);

  lsu_state_e            state_q;
  logic [1:0]            idx_q;
  logic [1:0]            last_q;
  logic [DATA_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  we_q;
  logic                  zext_q;
  logic [1:0]            size_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;

  logic [1:0]            req_size;
  logic                  req_zext;
  logic                  size_invalid;
  logic                  misaligned;
  logic                  aligned_ok;
  logic                  req_err;
  logic                  go_split;
  logic [7:0]            wbyte;
  logic [DATA_WIDTH-1:0] assembled;
  logic [1:0]            ext_size;
  logic                  ext_zext;
  logic [DATA_WIDTH-1:0] ext_in;
  logic [DATA_WIDTH-1:0] ext_out;

  assign req_size     = bus.req_ctrl[1:0];
  assign req_zext     = bus.req_ctrl[CTRL_ZEXT];
  assign size_invalid = (req_size == 2'b11);
  assign misaligned   = ((req_size == SZ_HALF) && bus.req_addr[0]) ||
                        ((req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign aligned_ok   = bus.req_valid && !size_invalid && !misaligned;
  assign req_err      = bus.req_valid && (size_invalid || (misaligned && !SPLIT_MISALIGNED));
  assign go_split     = (state_q == IDLE) && bus.req_valid && misaligned && SPLIT_MISALIGNED;

  assign wbyte = wdata_q[{idx_q, 3'b000} +: 8];

  // The byte arriving this cycle is merged here. This lets the final SPLIT
  // cycle extend the complete value without an extra cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_assemble
      assign assembled[gi*8 +: 8] = ((gi < 4) && (int'(idx_q) == gi)) ?
                                    bus.mem_RD[7:0] : buf_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    if (state_q == SPLIT) begin
      ext_size = size_q;
      ext_zext = zext_q;
      ext_in   = assembled;
    end else begin
      ext_size = req_size;
      ext_zext = req_zext;
      ext_in   = bus.mem_RD;
    end
  end

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .size_i (ext_size),
    .zext_i (ext_zext),
    .data_i (ext_in),
    .data_o (ext_out)
  );

  // The memory bus is combinational so that aligned accesses finish in the
  // request cycle. It is held quiet while reset is asserted.
  always_comb begin
    bus.mem_A                 = '0;
    bus.mem_WE                = 1'b0;
    bus.mem_AddressingControl = 3'b000;
    bus.mem_WD                = '0;
    bus.busy                  = 1'b0;
    if (!rst) begin
      if (state_q == SPLIT) begin
        bus.mem_A                 = base_q + DATA_WIDTH'(idx_q);
        bus.mem_WE                = we_q;
        bus.mem_AddressingControl = we_q ? 3'b000 : {1'b1, SZ_BYTE};
        bus.mem_WD                = {{(DATA_WIDTH-8){1'b0}}, wbyte};
        bus.busy                  = 1'b1;
      end else begin
        bus.mem_A                 = bus.req_addr;
        bus.mem_WE                = aligned_ok && bus.req_we;
        bus.mem_AddressingControl = bus.req_ctrl;
        bus.mem_WD                = bus.req_wdata;
        bus.busy                  = go_split;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      last_q       <= 2'd0;
      base_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      we_q         <= 1'b0;
      zext_q       <= 1'b0;
      size_q       <= SZ_BYTE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (go_split) begin
            state_q <= SPLIT;
            idx_q   <= 2'd0;
            last_q  <= (req_size == SZ_HALF) ? 2'd1 : 2'd3;
            base_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            we_q    <= bus.req_we;
            zext_q  <= req_zext;
            size_q  <= req_size;
            buf_q   <= '0;
          end else if (req_err) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (aligned_ok) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= bus.req_we ? '0 : ext_out;
          end
        end
        SPLIT: begin
          if (!we_q) begin
            buf_q <= assembled;
          end
          idx_q <= idx_q + 2'd1;
          if (idx_q == last_q) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? '0 : ext_out;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master. It uses a byte-addressed memory model and
// a second instance built with misaligned splitting disabled.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  lsu_mem_master_if #(.DATA_WIDTH(32)) bus ();
  lsu_mem_master_if #(.DATA_WIDTH(32)) bus_ns ();

  lsu_mem_master #(.DATA_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  lsu_mem_master #(.DATA_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk (clk),
    .rst (rst),
    .bus (bus_ns.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  logic       pl_en;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;
  logic [9:0] ia;
  logic [9:0] ib;

  assign ia = bus.mem_A[9:0];
  assign ib = bus_ns.mem_A[9:0];

  always_comb begin
    bus.mem_RD    = {mem[ia + 10'd3], mem[ia + 10'd2], mem[ia + 10'd1], mem[ia]};
    bus_ns.mem_RD = {mem[ib + 10'd3], mem[ib + 10'd2], mem[ib + 10'd1], mem[ib]};
  end

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_WE) begin
      mem[ia] <= bus.mem_WD[7:0];
      if (bus.mem_AddressingControl[1:0] != SZ_BYTE) mem[ia + 10'd1] <= bus.mem_WD[15:8];
      if (bus.mem_AddressingControl[1:0] == SZ_WORD) begin
        mem[ia + 10'd2] <= bus.mem_WD[23:16];
        mem[ia + 10'd3] <= bus.mem_WD[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_ctrl  = ctrl;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  // Single-cycle access. The call starts and ends 1 time unit after a rising edge.
  task automatic aligned(input string tag, input logic we, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    drive(we, ctrl, addr, wdata);
    @(negedge clk);
    check({tag, ".busy_req"}, 32'(bus.busy), 32'd0);
    check({tag, ".we_req"}, 32'(bus.mem_WE), 32'(we & ~exp_err));
    check({tag, ".addr_req"}, bus.mem_A, addr);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, ".resp_err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, ".busy_resp"}, 32'(bus.busy), 32'd0);
    $display("txn %s addr=0x%08h rdata=0x%08h err=%0d", tag, addr, bus.resp_rdata, bus.resp_err);
    @(posedge clk);
    #1;
  endtask

  // Misaligned access split into n byte cycles.
  task automatic split(input string tag, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata, input int n,
                       input logic [31:0] exp_rdata);
    logic [31:0] wd;
    wd = wdata;
    drive(we, ctrl, addr, wdata);
    @(negedge clk);
    check({tag, ".busy_req"}, 32'(bus.busy), 32'd1);
    check({tag, ".we_req"}, 32'(bus.mem_WE), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s.busy%0d", tag, i), 32'(bus.busy), 32'd1);
      check($sformatf("%s.addr%0d", tag, i), bus.mem_A, addr + 32'(i));
      check($sformatf("%s.ctrl%0d", tag, i), 32'(bus.mem_AddressingControl),
            we ? 32'd0 : 32'd4);
      check($sformatf("%s.we%0d", tag, i), 32'(bus.mem_WE), 32'(we));
      if (we) check($sformatf("%s.wd%0d", tag, i), bus.mem_WD, {24'd0, wd[i*8 +: 8]});
      check($sformatf("%s.nresp%0d", tag, i), 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, ".resp_err"}, 32'(bus.resp_err), 32'd0);
    check({tag, ".rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, ".busy_resp"}, 32'(bus.busy), 32'd0);
    $display("txn %s addr=0x%08h rdata=0x%08h (split %0d)", tag, addr, bus.resp_rdata, n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    pl_en    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_ctrl = 3'b000;
    bus.req_addr  = '0;   bus.req_wdata = '0;
    bus_ns.req_valid = 1'b0; bus_ns.req_we = 1'b0; bus_ns.req_ctrl = 3'b000;
    bus_ns.req_addr  = '0;   bus_ns.req_wdata = '0;

    @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_err", 32'(bus.resp_err), 32'd0);
    check("rst.rdata", bus.resp_rdata, 32'd0);
    check("rst.mem_we", 32'(bus.mem_WE), 32'd0);
    check("rst.mem_a", bus.mem_A, 32'd0);
    check("rst.mem_wd", bus.mem_WD, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    poke(10'h100, 8'h80); poke(10'h101, 8'h7F); poke(10'h102, 8'h12);
    poke(10'h103, 8'hF0); poke(10'h104, 8'hAA);
    poke(10'h001, 8'h34); poke(10'h002, 8'h85);
    for (int i = 0; i < 6; i++) poke(10'h300 + 10'(i), 8'h00);

    @(negedge clk);
    check("idle.resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;

    aligned("lb_100", 1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFF80, 1'b0);
    aligned("lbu_100", 1'b0, 3'b100, 32'h100, 32'h0, 32'h00000080, 1'b0);
    aligned("lh_102", 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFFF012, 1'b0);

    // Back-to-back: the second request is issued in the cycle the first response is valid.
    drive(1'b0, 3'b000, 32'h100, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 3'b000, 32'h103, 32'h0);
    @(negedge clk);
    check("b2b.resp1", bus.resp_rdata, 32'hFFFFFF80);
    check("b2b.valid1", 32'(bus.resp_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b.resp2", bus.resp_rdata, 32'hFFFFFFF0);
    check("b2b.valid2", 32'(bus.resp_valid), 32'd1);
    $display("txn b2b lb 0x100 then lb 0x103");
    @(posedge clk);
    #1;

    split("lw_101", 1'b0, 3'b010, 32'h101, 32'h0, 4, 32'hAAF0127F);
    split("sw_203", 1'b1, 3'b010, 32'h203, 32'hDEADBEEF, 4, 32'h0);
    check("sw_203.m203", 32'(mem[10'h203]), 32'hEF);
    check("sw_203.m204", 32'(mem[10'h204]), 32'hBE);
    check("sw_203.m205", 32'(mem[10'h205]), 32'hAD);
    check("sw_203.m206", 32'(mem[10'h206]), 32'hDE);
    split("lw_203", 1'b0, 3'b010, 32'h203, 32'h0, 4, 32'hDEADBEEF);
    split("lh_001", 1'b0, 3'b001, 32'h001, 32'h0, 2, 32'hFFFF8534);
    split("lhu_001", 1'b0, 3'b101, 32'h001, 32'h0, 2, 32'h00008534);

    aligned("inv_ld", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1);
    aligned("inv_st", 1'b1, 3'b011, 32'h100, 32'h12345678, 32'h0, 1'b1);
    check("inv_st.mem", 32'(mem[10'h100]), 32'h80);

    // Instance with splitting disabled: misaligned requests are errors.
    bus_ns.req_valid = 1'b1; bus_ns.req_we = 1'b0; bus_ns.req_ctrl = 3'b010;
    bus_ns.req_addr = 32'h101;
    @(negedge clk);
    check("ns_lw.busy", 32'(bus_ns.busy), 32'd0);
    check("ns_lw.we", 32'(bus_ns.mem_WE), 32'd0);
    @(posedge clk);
    #1;
    bus_ns.req_addr = 32'h100;
    @(negedge clk);
    check("ns_lw.resp_valid", 32'(bus_ns.resp_valid), 32'd1);
    check("ns_lw.resp_err", 32'(bus_ns.resp_err), 32'd1);
    check("ns_lw.rdata", bus_ns.resp_rdata, 32'd0);
    @(posedge clk);
    #1;
    bus_ns.req_valid = 1'b0;
    @(negedge clk);
    check("ns_lw_al.resp_err", 32'(bus_ns.resp_err), 32'd0);
    check("ns_lw_al.rdata", bus_ns.resp_rdata, 32'hF0127F80);
    $display("txn ns lw 0x101 (err) then lw 0x100");
    @(posedge clk);
    #1;

    // Reset during the second SPLIT cycle of a misaligned store.
    drive(1'b1, 3'b010, 32'h301, 32'h11223344);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_sw.busy_s0", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_sw.busy", 32'(bus.busy), 32'd0);
    check("rst_sw.we", 32'(bus.mem_WE), 32'd0);
    check("rst_sw.resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_sw.resp_after", 32'(bus.resp_valid), 32'd0);
    check("rst_sw.busy_after", 32'(bus.busy), 32'd0);
    check("rst_sw.m301", 32'(mem[10'h301]), 32'h44);
    check("rst_sw.m302", 32'(mem[10'h302]), 32'h00);
    check("rst_sw.m303", 32'(mem[10'h303]), 32'h00);
    check("rst_sw.m304", 32'(mem[10'h304]), 32'h00);
    $display("txn rst_sw sw 0x301 aborted by reset");
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
